uart_pic_loader: RTL and testbench

//  Parametrised UART receiver that loads one image, byte per pixel, into a

---
 rtl/uart_pic_loader_if.sv | 47 ++++
 rtl/uart_pic_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_pic_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pic_loader_if.sv
// -----------------------------------------------------------------------------
// uart_pic_loader_if
//   Bundles the UART image loader's line input, consumer handshake, RAM write
//   port and status pulses. Signal prefixes are from the loader's point of
//   view: i_* flow into the loader, o_* flow out of it.
//
//   master : the loader itself (drives o_*, receives i_*)
//   slave  : the environment (rx line driver, image RAM, consumer)
//
//   i_rx          async UART line, idle high
//   i_pic_ack     consumer has read the image (effective only while o_pic_valid)
//   o_wr_en       one-cycle RAM write strobe
//   o_wr_addr     pixel index 0..PIX_COUNT-1
//   o_wr_data     received pixel
//   o_pic_valid   level: full image stored
//   o_busy        frame reception in progress
//   o_frame_err   one-cycle pulse: stop bit sampled low
//   o_parity_err  one-cycle pulse: parity mismatch
//   o_overrun     one-cycle pulse: good byte dropped while o_pic_valid
// -----------------------------------------------------------------------------
interface uart_pic_loader_if #(
  parameter int ADDR_W    = 10,
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic                 i_pic_ack;
  logic                 o_wr_en;
  logic [ADDR_W-1:0]    o_wr_addr;
  logic [DATA_BITS-1:0] o_wr_data;
  logic                 o_pic_valid;
  logic                 o_busy;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_overrun;

  modport master (
    input  i_rx, i_pic_ack,
    output o_wr_en, o_wr_addr, o_wr_data, o_pic_valid, o_busy,
           o_frame_err, o_parity_err, o_overrun
  );

  modport slave (
    output i_rx, i_pic_ack,
    input  o_wr_en, o_wr_addr, o_wr_data, o_pic_valid, o_busy,
           o_frame_err, o_parity_err, o_overrun
  );
endinterface

// File: rtl/uart_pic_loader.sv
// -----------------------------------------------------------------------------
// uart_pic_loader
//   UART receiver that loads one image, one byte per pixel, into a write-port
//   RAM and raises pic_valid once the image is complete. Frames are checked
//   for false starts, parity (optional) and stop bit. With SYNC_EN set, every
//   image must be preceded by SYNC_BYTE; bytes before it are discarded.
//   A completed image is held until the consumer acknowledges it; good bytes
//   arriving meanwhile are dropped with an overrun pulse.
//
// Ports
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   uart_pic_loader_if.master (rx line, ack, RAM write port, status)
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit
//   DATA_BITS     payload bits per frame (5..8), LSB first
//   PARITY        0 = none, 1 = odd, 2 = even
//   PIX_COUNT     bytes per image
//   ADDR_W        write address width, 2**ADDR_W >= PIX_COUNT
//   SYNC_EN       1 = image must be preceded by SYNC_BYTE
//   SYNC_BYTE     header value, compared on the low DATA_BITS bits
// -----------------------------------------------------------------------------
module uart_pic_loader #(
  parameter int         CLKS_PER_BIT = 10417,
  parameter int         DATA_BITS    = 8,
  parameter int         PARITY       = 0,
  parameter int         PIX_COUNT    = 784,
  parameter int         ADDR_W       = 10,
  parameter int         SYNC_EN      = 1,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  uart_pic_loader_if.master  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0]     HALF_LAST   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST    = BIT_W'(DATA_BITS - 1);
  localparam logic [ADDR_W-1:0]    PIX_LAST    = ADDR_W'(PIX_COUNT - 1);
  localparam logic [DATA_BITS-1:0] SYNC_VAL    = SYNC_BYTE[DATA_BITS-1:0];
  localparam logic                 SYNC_EN_BIT = (SYNC_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // rx synchroniser and edge detector
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;

  // frame reception
  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;

  // image bookkeeping and outputs
  logic [ADDR_W-1:0]    r_index;
  logic                 r_hunting;
  logic                 r_pic_valid;
  logic                 r_set_valid;
  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  // FSM control strobes
  logic                 w_start_edge;
  logic                 w_cnt_clr;
  logic                 w_bit_clr;
  logic                 w_shift_en;
  logic                 w_par_cap;
  logic                 w_byte_done;
  logic                 w_ones;
  logic                 w_parity_ok;

  // ---------------------------------------------------------------------------
  // rx synchroniser. Flops reset to the idle level so that releasing reset
  // never looks like a start edge.
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // A start needs a 1 -> 0 transition, so a line stuck low cannot retrigger.
  assign w_start_edge = r_rx_prev & ~r_rx_sync;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control strobes. START samples half a bit in; every
  // later sample is one full bit after the previous because the counter is
  // cleared on each sample.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_bit_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_par_cap    = 1'b0;
    w_byte_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_start_edge) w_state_next = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr    = 1'b1;
          w_bit_clr    = 1'b1;
          // A high mid-start sample is line noise: drop it silently.
          w_state_next = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_LAST)
            w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_clr    = 1'b1;
          w_par_cap    = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so a start edge in its second half is caught.
        if (r_cnt == FULL_LAST) begin
          w_cnt_clr    = 1'b1;
          w_byte_done  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit timing counter, data shifter, parity capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else begin
      if (w_cnt_clr) r_cnt <= '0;
      else           r_cnt <= r_cnt + 1'b1;

      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;

      // LSB arrives first, so shift in from the top.
      if (w_shift_en) r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
      if (w_par_cap)  r_par_bit <= r_rx_sync;
    end
  end

  // Odd parity: data+parity has an odd number of ones; even: an even number.
  assign w_ones = ^{r_shift, r_par_bit};
  always_comb begin
    w_parity_ok = 1'b1;
    if (PARITY == 1)      w_parity_ok = w_ones;
    else if (PARITY == 2) w_parity_ok = ~w_ones;
  end

  // ---------------------------------------------------------------------------
  // Byte outcome. Decided at the stop sample edge (r_rx_sync is the stop bit),
  // so the strobes are visible during the cycle after that sample.
  // Priority: frame error, parity error, overrun, sync hunt, write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index      <= '0;
      r_hunting    <= SYNC_EN_BIT;
      r_pic_valid  <= 1'b0;
      r_set_valid  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_set_valid  <= 1'b0;

      // pic_valid rises the cycle after the last pixel's write strobe.
      if (r_set_valid)                      r_pic_valid <= 1'b1;
      else if (bus.i_pic_ack && r_pic_valid) r_pic_valid <= 1'b0;

      if (w_byte_done) begin
        if (!r_rx_sync) begin
          r_frame_err <= 1'b1;
        end else if (!w_parity_ok) begin
          r_parity_err <= 1'b1;
        end else if (r_pic_valid) begin
          r_overrun <= 1'b1;
        end else if (r_hunting) begin
          if (r_shift == SYNC_VAL) r_hunting <= 1'b0;
        end else begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_index;
          r_wr_data <= r_shift;
          if (r_index == PIX_LAST) begin
            r_index     <= '0;
            r_hunting   <= SYNC_EN_BIT;
            r_set_valid <= 1'b1;
          end else begin
            r_index <= r_index + 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_wr_en      = r_wr_en;
  assign bus.o_wr_addr    = r_wr_addr;
  assign bus.o_wr_data    = r_wr_data;
  assign bus.o_pic_valid  = r_pic_valid;
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_frame_err  = r_frame_err;
  assign bus.o_parity_err = r_parity_err;
  assign bus.o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_pic_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_pic_loader
//   Directed bench for uart_pic_loader. dut0: no parity, 4-pixel images with
//   sync header A5. dut1: same but even parity. Monitors on the falling edge
//   log write strobes and count status pulses; each test task compares the
//   logged activity against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uart_pic_loader;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_pic_loader_if #(.ADDR_W(2), .DATA_BITS(8)) bus0 ();
  uart_pic_loader_if #(.ADDR_W(2), .DATA_BITS(8)) bus1 ();

  uart_pic_loader #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .PIX_COUNT(4),
    .ADDR_W(2), .SYNC_EN(1), .SYNC_BYTE(8'hA5)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  uart_pic_loader #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .PIX_COUNT(4),
    .ADDR_W(2), .SYNC_EN(1), .SYNC_BYTE(8'hA5)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int pass_n = 0;
  int chk_n  = 0;

  // dut0 monitor
  int         cyc        = 0;
  logic [1:0] q_addr[$];
  logic [7:0] q_data[$];
  int         q_cyc[$];
  int         ferr_n     = 0;
  int         perr_n     = 0;
  int         ovr_n      = 0;
  int         busy_n     = 0;
  int         valid_rise = -1;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus0.o_wr_en) begin
      q_addr.push_back(bus0.o_wr_addr);
      q_data.push_back(bus0.o_wr_data);
      q_cyc.push_back(cyc);
    end
    if (bus0.o_frame_err)  ferr_n <= ferr_n + 1;
    if (bus0.o_parity_err) perr_n <= perr_n + 1;
    if (bus0.o_overrun)    ovr_n  <= ovr_n + 1;
    if (bus0.o_busy)       busy_n <= busy_n + 1;
    if (bus0.o_pic_valid && !prev_valid) valid_rise <= cyc;
    prev_valid <= bus0.o_pic_valid;
  end

  // dut1 monitor
  int         p_wr_n   = 0;
  logic [1:0] p_addr   = '0;
  logic [7:0] p_data   = '0;
  int         p_perr_n = 0;
  int         p_ferr_n = 0;

  always @(negedge clk) begin
    if (bus1.o_wr_en) begin
      p_wr_n <= p_wr_n + 1;
      p_addr <= bus1.o_wr_addr;
      p_data <= bus1.o_wr_data;
    end
    if (bus1.o_parity_err) p_perr_n <= p_perr_n + 1;
    if (bus1.o_frame_err)  p_ferr_n <= p_ferr_n + 1;
  end

  // Drive one rx line for n cycles.
  task automatic drive(input int dut, input logic v, input int n);
    if (dut == 0) bus0.i_rx = v;
    else          bus1.i_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Full frame: start, 8 data bits LSB first, optional parity, stop, idle gap.
  task automatic send_frame(input int dut, input logic [7:0] b, input bit use_par,
                            input bit par, input bit stop, input int gap_bits);
    drive(dut, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(dut, b[i], CPB);
    if (use_par) drive(dut, par, CPB);
    drive(dut, stop, CPB);
    drive(dut, 1'b1, gap_bits * CPB);
  endtask

  task automatic pulse_ack();
    bus0.i_pic_ack = 1'b1;
    @(negedge clk);
    bus0.i_pic_ack = 1'b0;
  endtask

  task automatic test_reset();
    chk_n++;
    if ({bus0.o_wr_en, bus0.o_pic_valid, bus0.o_busy} !== 3'b000) begin
      $display("FAIL reset_ctrl: got wr_en/valid/busy=%b want 000",
               {bus0.o_wr_en, bus0.o_pic_valid, bus0.o_busy});
    end else pass_n++;
    chk_n++;
    if ({bus0.o_frame_err, bus0.o_parity_err, bus0.o_overrun} !== 3'b000) begin
      $display("FAIL reset_flags: got ferr/perr/ovr=%b want 000",
               {bus0.o_frame_err, bus0.o_parity_err, bus0.o_overrun});
    end else pass_n++;
    chk_n++;
    if ({bus0.o_wr_addr, bus0.o_wr_data} !== 10'h000) begin
      $display("FAIL reset_wr_port: got addr=%0d data=%h want 0/00",
               bus0.o_wr_addr, bus0.o_wr_data);
    end else pass_n++;
  endtask

  task automatic test_basic();
    int         b;
    logic [7:0] exp[4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    b = q_addr.size();
    send_frame(0, 8'hA5, 0, 0, 1, 0);
    send_frame(0, 8'h11, 0, 0, 1, 0);
    send_frame(0, 8'h22, 0, 0, 1, 0);
    send_frame(0, 8'h33, 0, 0, 1, 0);
    send_frame(0, 8'h44, 0, 0, 1, 2);
    chk_n++;
    if (q_addr.size() - b !== 4) begin
      $display("FAIL basic_count: got %0d writes want 4", q_addr.size() - b);
    end else begin
      pass_n++;
      for (int i = 0; i < 4; i++) begin
        chk_n++;
        if ({q_addr[b+i], q_data[b+i]} !== {2'(i), exp[i]})
          $display("FAIL basic_wr%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   i, q_addr[b+i], q_data[b+i], i, exp[i]);
        else pass_n++;
      end
      chk_n++;
      if (valid_rise !== q_cyc[b+3] + 1)
        $display("FAIL basic_valid_time: got rise at %0d want %0d", valid_rise, q_cyc[b+3] + 1);
      else pass_n++;
    end
    chk_n++;
    if (bus0.o_pic_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bus0.o_pic_valid);
    else pass_n++;
    chk_n++;
    if (ferr_n + perr_n + ovr_n !== 0)
      $display("FAIL basic_flags: got %0d error pulses want 0", ferr_n + perr_n + ovr_n);
    else pass_n++;
  endtask

  task automatic test_sync_hunt();
    int         b;
    logic [7:0] exp[4];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulse_ack();
    chk_n++;
    if (bus0.o_pic_valid !== 1'b0) $display("FAIL hunt_ack: got valid=%b want 0", bus0.o_pic_valid);
    else pass_n++;
    b = q_addr.size();
    send_frame(0, 8'h3C, 0, 0, 1, 0);
    send_frame(0, 8'hA5, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) send_frame(0, exp[i], 0, 0, 1, (i == 3) ? 2 : 0);
    chk_n++;
    if (q_addr.size() - b !== 4) begin
      $display("FAIL hunt_count: got %0d writes want 4", q_addr.size() - b);
    end else begin
      pass_n++;
      for (int i = 0; i < 4; i++) begin
        chk_n++;
        if ({q_addr[b+i], q_data[b+i]} !== {2'(i), exp[i]})
          $display("FAIL hunt_wr%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   i, q_addr[b+i], q_data[b+i], i, exp[i]);
        else pass_n++;
      end
    end
    chk_n++;
    if (bus0.o_pic_valid !== 1'b1) $display("FAIL hunt_valid: got %b want 1", bus0.o_pic_valid);
    else pass_n++;
  endtask

  task automatic test_overrun();
    int b;
    int o;
    b = q_addr.size();
    o = ovr_n;
    send_frame(0, 8'h55, 0, 0, 1, 2);
    chk_n++;
    if (ovr_n - o !== 1) $display("FAIL ovr_pulse: got %0d pulses want 1", ovr_n - o);
    else pass_n++;
    chk_n++;
    if (q_addr.size() - b !== 0) $display("FAIL ovr_nowrite: got %0d writes want 0", q_addr.size() - b);
    else pass_n++;
    chk_n++;
    if (bus0.o_pic_valid !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", bus0.o_pic_valid);
    else pass_n++;
    pulse_ack();
    chk_n++;
    if (bus0.o_pic_valid !== 1'b0) $display("FAIL ovr_ack: got valid=%b want 0", bus0.o_pic_valid);
    else pass_n++;
    send_frame(0, 8'hA5, 0, 0, 1, 0);
    send_frame(0, 8'h09, 0, 0, 1, 2);
    chk_n++;
    if (q_addr.size() - b !== 1) $display("FAIL ovr_after_count: got %0d writes want 1", q_addr.size() - b);
    else begin
      pass_n++;
      chk_n++;
      if ({q_addr[b], q_data[b]} !== {2'd0, 8'h09})
        $display("FAIL ovr_after_wr: got addr=%0d data=%h want addr=0 data=09", q_addr[b], q_data[b]);
      else pass_n++;
    end
  endtask

  task automatic test_frame_err();
    int b;
    int f;
    int p;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b = q_addr.size();
    f = ferr_n;
    p = perr_n;
    send_frame(0, 8'hA5, 0, 0, 1, 0);
    send_frame(0, 8'h77, 0, 0, 0, 1);
    chk_n++;
    if (ferr_n - f !== 1) $display("FAIL ferr_pulse: got %0d pulses want 1", ferr_n - f);
    else pass_n++;
    chk_n++;
    if (q_addr.size() - b !== 0) $display("FAIL ferr_nowrite: got %0d writes want 0", q_addr.size() - b);
    else pass_n++;
    send_frame(0, 8'h78, 0, 0, 1, 2);
    chk_n++;
    if (q_addr.size() - b !== 1) $display("FAIL ferr_next_count: got %0d writes want 1", q_addr.size() - b);
    else begin
      pass_n++;
      chk_n++;
      if ({q_addr[b], q_data[b]} !== {2'd0, 8'h78})
        $display("FAIL ferr_next_wr: got addr=%0d data=%h want addr=0 data=78", q_addr[b], q_data[b]);
      else pass_n++;
    end
    chk_n++;
    if (perr_n - p !== 0) $display("FAIL ferr_no_perr: got %0d parity pulses want 0", perr_n - p);
    else pass_n++;
  endtask

  task automatic test_false_start_and_reset();
    int b;
    int bz;
    int fl;
    b  = q_addr.size();
    bz = busy_n;
    fl = ferr_n + perr_n + ovr_n;
    drive(0, 1'b0, 6);
    drive(0, 1'b1, 3 * CPB);
    // START lasts counts 0..CPB/2-1, then the high sample returns to IDLE.
    chk_n++;
    if (busy_n - bz !== CPB / 2) $display("FAIL false_busy_len: got %0d busy cycles want %0d", busy_n - bz, CPB / 2);
    else pass_n++;
    chk_n++;
    if ({bus0.o_busy, q_addr.size() - b, ferr_n + perr_n + ovr_n - fl} !== {1'b0, 32'd0, 32'd0})
      $display("FAIL false_quiet: got busy=%b writes=%0d flags=%0d want 0/0/0",
               bus0.o_busy, q_addr.size() - b, ferr_n + perr_n + ovr_n - fl);
    else pass_n++;

    // Index is 1 after the previous test, so this A5 is a pixel at address 1.
    send_frame(0, 8'hA5, 0, 0, 1, 0);
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, CPB);
    rst = 1'b1;
    bus0.i_rx = 1'b1;
    @(negedge clk);
    chk_n++;
    if ({bus0.o_wr_en, bus0.o_pic_valid, bus0.o_busy, bus0.o_frame_err,
         bus0.o_parity_err, bus0.o_overrun, bus0.o_wr_addr, bus0.o_wr_data} !== 16'h0000)
      $display("FAIL rst_outputs: got busy=%b valid=%b addr=%0d data=%h want all 0",
               bus0.o_busy, bus0.o_pic_valid, bus0.o_wr_addr, bus0.o_wr_data);
    else pass_n++;
    rst = 1'b0;
    drive(0, 1'b1, 2 * CPB);
    chk_n++;
    if (q_addr.size() - b !== 1) $display("FAIL rst_pre_count: got %0d writes want 1", q_addr.size() - b);
    else begin
      pass_n++;
      chk_n++;
      if ({q_addr[b], q_data[b]} !== {2'd1, 8'hA5})
        $display("FAIL rst_pre_wr: got addr=%0d data=%h want addr=1 data=a5", q_addr[b], q_data[b]);
      else pass_n++;
    end
    b = q_addr.size();
    send_frame(0, 8'hA5, 0, 0, 1, 0);
    send_frame(0, 8'hAA, 0, 0, 1, 2);
    chk_n++;
    if (q_addr.size() - b !== 1) $display("FAIL rst_restart_count: got %0d writes want 1", q_addr.size() - b);
    else begin
      pass_n++;
      chk_n++;
      if ({q_addr[b], q_data[b]} !== {2'd0, 8'hAA})
        $display("FAIL rst_restart_wr: got addr=%0d data=%h want addr=0 data=aa", q_addr[b], q_data[b]);
      else pass_n++;
    end
  endtask

  task automatic test_parity();
    // A5 has four ones: even parity bit 0. 03 has two ones: even parity bit 0.
    send_frame(1, 8'hA5, 1, 1'b0, 1, 0);
    send_frame(1, 8'h03, 1, 1'b1, 1, 0);
    send_frame(1, 8'h03, 1, 1'b0, 1, 2);
    chk_n++;
    if (p_perr_n !== 1) $display("FAIL par_pulse: got %0d parity pulses want 1", p_perr_n);
    else pass_n++;
    chk_n++;
    if (p_ferr_n !== 0) $display("FAIL par_no_ferr: got %0d frame pulses want 0", p_ferr_n);
    else pass_n++;
    chk_n++;
    if ({p_wr_n, p_addr, p_data} !== {32'd1, 2'd0, 8'h03})
      $display("FAIL par_write: got writes=%0d addr=%0d data=%h want 1/0/03", p_wr_n, p_addr, p_data);
    else pass_n++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus0.i_rx      = 1'b1;
    bus0.i_pic_ack = 1'b0;
    bus1.i_rx      = 1'b1;
    bus1.i_pic_ack = 1'b0;
    rst            = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_basic();
    test_sync_hunt();
    test_overrun();
    test_frame_err();
    test_false_start_and_reset();
    test_parity();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
